multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
- Parametrised N-channel button debouncer for push-button inputs, sitting between board pins and control FSMs.
- Per channel: synchronises the raw input, filters bounce with a programmable stability count, and exports a clean level.
- Also exports one-cycle press and release pulses, plus an optional auto-repeat pulse train while a button is held.

Parameters:
- N_CH, 4, number of independent button channels.
- CNT_W, 12, width of each debounce counter; must satisfy DB_CYCLES < 2^CNT_W.
- DB_CYCLES, 1023, consecutive synchronised cycles of a new level required to accept it; legal range >= 2.
- RPT_W, 24, width of each repeat counter.
- RPT_DELAY, 5000000, held cycles after the press pulse before the first repeat pulse; legal range >= 2, must be < 2^RPT_W.
- RPT_PERIOD, 1000000, cycles between subsequent repeat pulses; legal range >= 2, must be < 2^RPT_W.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  N_CH  raw asynchronous button inputs, active high.
- rpt_en  input  1  synchronous global auto-repeat enable.
- db_level  output  N_CH  debounced level, registered.
- press_pulse  output  N_CH  one-cycle pulse on accepted 0->1.
- release_pulse  output  N_CH  one-cycle pulse on accepted 1->0.
- repeat_pulse  output  N_CH  one-cycle auto-repeat pulses while held.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following to 0: sync flops, counters, repeat phase (IDLE), db_level, press_pulse, release_pulse, repeat_pulse.
- Synchroniser: each channel has a 2-flop chain, s1 <= btn[i], s2 <= s1.
- Filter: db_level[i] is the accepted state.
  - If s2 == db_level, cnt <= 0. Any bounce restarts the count.
  - If s2 != db_level and cnt < DB_CYCLES-1, cnt <= cnt+1.
  - If s2 != db_level and cnt == DB_CYCLES-1:
    - db_level <= s2 and cnt <= 0.
    - press_pulse <= 1 if s2 = 1, otherwise release_pulse <= 1.
  - Pulses are registered and high for exactly one cycle.
- Latency: with btn changed and stable before rising edge 1, db_level and the pulse become visible after edge DB_CYCLES+2.
- Counter never exceeds DB_CYCLES-1 and never wraps.
- Auto-repeat, per channel, 3-state FSM IDLE/DELAY/REPEAT with counter rcnt:
  - IDLE -> DELAY on the edge that asserts press_pulse, if rpt_en = 1; rcnt <= 0.
  - DELAY: rcnt increments each cycle. At rcnt == RPT_DELAY-1: repeat_pulse <= 1, rcnt <= 0, -> REPEAT.
  - REPEAT: rcnt increments each cycle. At rcnt == RPT_PERIOD-1: repeat_pulse <= 1, rcnt <= 0.
  - Any state -> IDLE with rcnt <= 0, no pulse, when db_level falls (same edge as release_pulse) or rpt_en = 0 is sampled.
  - rpt_en rising while a button is already held does not start repeat; repeat arms only on a new press.
- Press pulse and first repeat pulse are never coincident (RPT_DELAY >= 2).
- Channels are fully independent: simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset mid-operation: all pulses drop immediately. A button held through reset release is treated as a new press and needs the full DB_CYCLES+2 cycles after the first sampling edge.
- Glitch narrower than one clock may be missed by the synchroniser; this is acceptable.

Test Plan (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, N_CH=4):
- Clean press: btn[0] 0->1 before edge 1, held -> press_pulse[0] high one cycle after edge 6, db_level[0]=1 from edge 6; other channels stay 0.
- Bounce: btn[1] toggles 1,0,1,0 on successive cycles, then held 1 -> no pulse during bouncing; press_pulse[1] exactly 6 edges after the final rise.
- Release: hold btn[0] then drop to 0 -> release_pulse[0] one cycle, 6 edges after the drop; no repeat_pulse when rpt_en = 0.
- Auto-repeat: rpt_en = 1, hold btn[2] -> press at edge 6; repeat_pulse[2] at edges 16, 19, 22, ...; release stops repeats, and no repeat pulse occurs on or after the release_pulse edge.
- Simultaneous: btn[3:0] = 4'b1111 at once -> press_pulse = 4'b1111 in the same cycle. Then drop only btn[1] -> release_pulse = 4'b0010.
- Reset mid-count: assert rst_n low at edge 4 with btn[0] held, release at edge 8 -> all outputs 0 during reset; press_pulse[0] 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce
// Purpose  : N-channel push-button debouncer. Each channel synchronises its
//            raw input, accepts a new level only after it has been stable for
//            DB_CYCLES consecutive synchronised cycles, and produces one-cycle
//            press/release pulses plus an optional auto-repeat pulse train.
// Ports    : clk           - system clock, rising edge
//            rst_n         - asynchronous active-low reset
//            btn           - raw asynchronous button inputs (active high)
//            rpt_en        - global auto-repeat enable (synchronous)
//            db_level      - debounced level per channel (registered)
//            press_pulse   - one-cycle pulse on accepted 0->1
//            release_pulse - one-cycle pulse on accepted 1->0
//            repeat_pulse  - one-cycle auto-repeat pulses while held
// Revision : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 12,
  parameter int DB_CYCLES  = 1023,
  parameter int RPT_W      = 24,
  parameter int RPT_DELAY  = 5000000,
  parameter int RPT_PERIOD = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  input  logic            rpt_en,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] C_DELAY_LAST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] C_PER_LAST   = RPT_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_accept;
    logic             w_rise;
    logic             w_fall;

    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [RPT_W-1:0] r_rcnt;
    logic [RPT_W-1:0] w_rcnt_nxt;
    logic             r_rpt;
    logic             w_rpt_nxt;

    // The new level is accepted on the edge where the counter has already
    // seen DB_CYCLES-1 differing cycles and the current one still differs.
    assign w_accept = (r_s2 != r_level) && (r_cnt == C_CNT_LAST);
    assign w_rise   = w_accept && r_s2;
    assign w_fall   = w_accept && !r_s2;

    // Synchroniser and stability filter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_s1      <= btn[i];
        r_s2      <= r_s1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (r_s2 == r_level) begin
          // Any bounce back to the accepted level restarts the count.
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt     <= '0;
          r_level   <= r_s2;
          r_press   <= r_s2;
          r_release <= !r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // Auto-repeat FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_rpt   <= w_rpt_nxt;
      end
    end

    // Auto-repeat FSM: next state. Repeat arms only on a fresh press edge, so
    // enabling rpt_en while a button is already held leaves the channel idle.
    // A release or a disabled rpt_en overrides any pending repeat pulse.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rpt_nxt   = 1'b0;
      if (!rpt_en || w_fall) begin
        w_state_nxt = S_IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_rcnt_nxt = '0;
            if (w_rise) begin
              w_state_nxt = S_DELAY;
            end
          end
          S_DELAY: begin
            if (r_rcnt == C_DELAY_LAST) begin
              w_rpt_nxt   = 1'b1;
              w_rcnt_nxt  = '0;
              w_state_nxt = S_REPEAT;
            end else begin
              w_rcnt_nxt = r_rcnt + 1'b1;
            end
          end
          S_REPEAT: begin
            if (r_rcnt == C_PER_LAST) begin
              w_rpt_nxt  = 1'b1;
              w_rcnt_nxt = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
      end
    end

    assign db_level[i]      = r_level;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign repeat_pulse[i]  = r_rpt;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debounce
// Purpose  : Directed self-checking bench for multi_debounce with
//            DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, N_CH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       rpt_en;
  logic [3:0] db_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;

  int checks   = 0;
  int failures = 0;
  logic [3:0] acc;

  multi_debounce #(
    .N_CH      (4),
    .CNT_W     (12),
    .DB_CYCLES (4),
    .RPT_W     (24),
    .RPT_DELAY (10),
    .RPT_PERIOD(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .rpt_en       (rpt_en),
    .db_level     (db_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] rpt);
    chk({tag, "_level"},   {28'd0, db_level},      {28'd0, lvl});
    chk({tag, "_press"},   {28'd0, press_pulse},   {28'd0, prs});
    chk({tag, "_release"}, {28'd0, release_pulse}, {28'd0, rel});
    chk({tag, "_repeat"},  {28'd0, repeat_pulse},  {28'd0, rpt});
  endtask

  initial begin
    rst_n  = 1'b0;
    btn    = 4'b0000;
    rpt_en = 1'b0;
    tick(3);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick(4);

    // Clean press on channel 0
    btn = 4'b0001;
    tick(5);
    chk_all("press0_e5", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("press0_e6", 4'h1, 4'h1, 4'h0, 4'h0);
    tick(1);
    chk_all("press0_e7", 4'h1, 4'h0, 4'h0, 4'h0);

    // Held with rpt_en=0: no repeat pulses
    acc = 4'h0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      acc |= repeat_pulse;
    end
    chk("hold_no_repeat", {28'd0, acc}, 32'h0);

    // Release channel 0
    btn = 4'b0000;
    tick(5);
    chk_all("rel0_e5", 4'h1, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("rel0_e6", 4'h0, 4'h0, 4'h1, 4'h0);
    tick(1);
    chk("rel0_e7", {28'd0, release_pulse}, 32'h0);

    // Bounce on channel 1: 1,0,1,0 then final rise and hold
    acc = 4'h0;
    btn = 4'b0010; tick(1); acc |= press_pulse;
    btn = 4'b0000; tick(1); acc |= press_pulse;
    btn = 4'b0010; tick(1); acc |= press_pulse;
    btn = 4'b0000; tick(1); acc |= press_pulse;
    btn = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      acc |= press_pulse;
    end
    chk("bounce_no_early_press", {28'd0, acc}, 32'h0);
    chk("bounce_level_low", {28'd0, db_level}, 32'h0);
    tick(1);
    chk_all("bounce_e6", 4'h2, 4'h2, 4'h0, 4'h0);
    btn = 4'b0000;
    tick(6);
    chk_all("bounce_rel", 4'h0, 4'h0, 4'h2, 4'h0);
    tick(4);

    // Auto-repeat on channel 2
    rpt_en = 1'b1;
    btn    = 4'b0100;
    tick(6);
    chk_all("rpt_press", 4'h4, 4'h4, 4'h0, 4'h0);
    for (int e = 7; e <= 22; e++) begin
      tick(1);
      chk($sformatf("rpt_e%0d", e), {28'd0, repeat_pulse},
          (e == 16 || e == 19 || e == 22) ? 32'h4 : 32'h0);
    end
    // Release lands on the edge where a repeat would otherwise fire (28)
    btn = 4'b0000;
    for (int e = 23; e <= 28; e++) begin
      tick(1);
      chk($sformatf("rpt_rel_e%0d", e), {28'd0, repeat_pulse},
          (e == 25) ? 32'h4 : 32'h0);
    end
    chk("rpt_release_pulse", {28'd0, release_pulse}, 32'h4);
    acc = 4'h0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      acc |= repeat_pulse;
    end
    chk("rpt_stopped", {28'd0, acc}, 32'h0);

    // rpt_en rising while channel 3 already held must not start repeats
    rpt_en = 1'b0;
    btn    = 4'b1000;
    tick(6);
    chk("held_press3", {28'd0, press_pulse}, 32'h8);
    rpt_en = 1'b1;
    acc = 4'h0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      acc |= repeat_pulse;
    end
    chk("late_enable_no_repeat", {28'd0, acc}, 32'h0);
    rpt_en = 1'b0;
    btn    = 4'b0000;
    tick(8);
    chk("settled_low", {28'd0, db_level}, 32'h0);

    // Simultaneous press on all channels, then drop only channel 1
    btn = 4'b1111;
    tick(6);
    chk_all("sim_press", 4'hF, 4'hF, 4'h0, 4'h0);
    btn = 4'b1101;
    tick(6);
    chk_all("sim_rel1", 4'hD, 4'h0, 4'h2, 4'h0);
    btn = 4'b0000;
    tick(8);

    // Reset in the middle of a debounce count
    btn = 4'b0001;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(4);
    chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    acc = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      acc |= press_pulse;
    end
    chk("post_rst_no_early", {28'd0, acc}, 32'h0);
    tick(1);
    chk_all("post_rst_e6", 4'h1, 4'h1, 4'h0, 4'h0);

    // Reset while a pulse is high drops it immediately
    rst_n = 1'b0;
    #1;
    chk_all("rst_drop", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
